// File: rtl/uart_pkg.sv
// Shared definitions for the result UART transmitter: FSM state encoding and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = DATA_BITS * BYTES_PER_WORD;

endpackage

// File: rtl/result_fifo.sv
// Single-clock synchronous FIFO with occupancy count; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);

  // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/result_uart_tx.sv
// Captures every change of the CPU result bus into a FIFO and streams each word
// out as four 8N1 UART bytes, most-significant byte first.
module result_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   result,
  input  logic                          capture_en,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  state_e                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic [31:0]            prev_q;
  logic                   tx_q, tx_d;
  logic                   busy_q;
  logic                   overflow_q;

  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [WORD_BITS-1:0]   fifo_rdata;
  logic                   baud_done;
  logic [DATA_BITS-1:0]   cur_byte;
  logic [2:0]             next_bit;

  assign push      = capture_en && (result != prev_q);
  assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign cur_byte  = shift_q[WORD_BITS-1 -: DATA_BITS];
  assign next_bit  = bit_idx_q + 3'd1;

  result_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (result),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // tx_d is the line level for the state being entered, so tx stays a clean register output.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_rdata;
          byte_idx_d = '0;
          baud_d     = '0;
          state_d    = ST_START;
          tx_d       = 1'b0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
          tx_d      = cur_byte[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = next_bit;
            tx_d      = cur_byte[next_bit];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (byte_idx_q != 2'(BYTES_PER_WORD - 1)) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = shift_q << DATA_BITS;
            state_d    = ST_START;
            tx_d       = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      prev_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      prev_q     <= result;
      tx_q       <= tx_d;
      busy_q     <= (state_d != ST_IDLE);
      overflow_q <= overflow_q | (push && fifo_full && !pop);
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; outputs sampled on falling edges.
module tb_result_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 40 * CPB;

  logic        clk;
  logic        rst;
  logic [31:0] result;
  logic        capture_en;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  result_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .result     (result),
    .capture_en (capture_en),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    result = 32'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_start();
    int waited;
    waited = 0;
    while (tx !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("start_timeout", (waited >= 50), 1'b0);
  endtask

  // Current falling edge is frame cycle 'start'; checks the whole frame and the idle cycle after it.
  task automatic check_word(input logic [31:0] word, input int start);
    int          tx_errs;
    int          busy_errs;
    int          b;
    int          pos;
    logic        e;
    logic [31:0] sh;
    logic [7:0]  exp_byte;
    logic [7:0]  rx [4];
    tx_errs   = 0;
    busy_errs = 0;
    for (int k = 0; k < 4; k++) rx[k] = 8'h00;
    for (int i = start; i < FRAME; i++) begin
      if (i > start) @(negedge clk);
      b        = i / 40;
      pos      = (i % 40) / CPB;
      sh       = word >> (8 * (3 - b));
      exp_byte = sh[7:0];
      if (pos == 0)      e = 1'b0;
      else if (pos == 9) e = 1'b1;
      else               e = exp_byte[pos-1];
      if (tx !== e)      tx_errs++;
      if (busy !== 1'b1) busy_errs++;
      if (((i % 40) % CPB) == 2 && pos >= 1 && pos <= 8) rx[b][pos-1] = tx;
    end
    check("frame_tx_cycles", tx_errs, 0);
    check("frame_busy_cycles", busy_errs, 0);
    for (int k = 0; k < 4; k++) begin
      sh = word >> (8 * (3 - k));
      check($sformatf("byte%0d", k), rx[k], sh[7:0]);
    end
    @(negedge clk);
    check("gap_tx", tx, 1'b1);
    check("gap_busy", busy, 1'b0);
  endtask

  task automatic idle_tally(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
    end
    check(tag, bad, 0);
  endtask

  logic [31:0] words [6];

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    result     = 32'h0;
    capture_en = 1'b0;
    words[0] = 32'h0123_4567;
    words[1] = 32'h89AB_CDEF;
    words[2] = 32'hFEDC_BA98;
    words[3] = 32'h7654_3210;
    words[4] = 32'h0F0F_F0F0;
    words[5] = 32'h3C3C_C3C3;

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_count", fifo_count, 3'd0);

    // Single word
    rst        = 1'b0;
    capture_en = 1'b1;
    result     = 32'hA5C3_0F81;
    @(negedge clk);
    check("single_count1", fifo_count, 3'd1);
    check("single_tx_idle", tx, 1'b1);
    @(negedge clk);
    check("single_count0", fifo_count, 3'd0);
    wait_start();
    check_word(32'hA5C3_0F81, 0);
    check("single_overflow", overflow, 1'b0);

    // Zero held after reset is never captured
    do_reset();
    capture_en = 1'b1;
    idle_tally("zero_idle", 50);

    // Capture gated
    capture_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      result = k * 32'h1111_1111;
      @(negedge clk);
    end
    capture_en = 1'b1;
    idle_tally("gated_idle", 20);

    // Burst of six consecutive changes into a four-deep FIFO
    do_reset();
    capture_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) check("burst_first_count", fifo_count, 3'd1);
      result = k;
      @(negedge clk);
    end
    check("burst_count_full", fifo_count, 3'd4);
    check("burst_overflow_set", overflow, 1'b1);
    check_word(32'd1, 4);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check_word(k, 0);
    end
    idle_tally("burst_drained", 20);
    check("burst_overflow_sticky", overflow, 1'b1);

    // Reset in the middle of byte 1 with two words queued
    do_reset();
    check("rst_clears_overflow", overflow, 1'b0);
    capture_en = 1'b1;
    result = 32'h1111_2222;
    @(negedge clk);
    result = 32'h3333_4444;
    @(negedge clk);
    result = 32'h5555_6666;
    @(negedge clk);
    repeat (59) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    check("mid_count", fifo_count, 3'd2);
    rst    = 1'b1;
    result = 32'h0;
    @(negedge clk);
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_count", fifo_count, 3'd0);
    rst = 1'b0;
    idle_tally("mid_no_frames", 60);

    // Full FIFO: push lands in the same cycle as the IDLE pop
    for (int k = 0; k < 5; k++) begin
      result = words[k];
      @(negedge clk);
    end
    check("sim_count_full", fifo_count, 3'd4);
    check_word(words[0], 3);
    result = words[5];
    @(negedge clk);
    check("sim_count_kept", fifo_count, 3'd4);
    check("sim_overflow", overflow, 1'b0);
    check_word(words[1], 0);
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      check_word(words[k], 0);
    end
    check("sim_overflow_end", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
